// File: rtl/m_rr_bus_arbiter.sv
// Round-robin owner selection for the shared data bus.
// Registers the owner's word onto the bus with a valid flag.
module m_rr_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 16,
  parameter int SEL_W    = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*DATA_W-1:0] i_data,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [SEL_W-1:0]        o_sel,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_valid,
  output logic                    o_busy
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int CW     = SEL_W + 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [N_REQ-1:0]  ONE      = N_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    gnt_d;
  logic [SEL_W-1:0]    sel_d;
  logic [DATA_W-1:0]   data_d;
  logic                valid_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [SEL_W-1:0]    last_q, last_d;

  logic                found;
  logic [SEL_W-1:0]    win;
  logic [CW-1:0]       cand;
  logic [DATA_W-1:0]   own_word;

  // Scan upward from the slot after the last owner, wrapping once.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, last_q} + CW'(i);
      if (cand >= CW'(N_REQ))
        cand = cand - CW'(N_REQ);
      if (!found && i_req[cand[SEL_W-1:0]]) begin
        found = 1'b1;
        win   = cand[SEL_W-1:0];
      end
    end
  end

  // Bus mux: word of the current owner.
  always_comb begin
    own_word = '0;
    for (int k = 0; k < N_REQ; k++)
      if (o_sel == SEL_W'(k))
        own_word = i_data[k*DATA_W +: DATA_W];
  end

  // Next-state and next-output logic of the ownership FSM.
  always_comb begin
    state_d = state_q;
    gnt_d   = o_gnt;
    sel_d   = o_sel;
    data_d  = o_data;
    valid_d = 1'b0;
    hold_d  = hold_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d   = ONE << win;
          sel_d   = win;
          last_d  = win;
          hold_d  = HOLD_W'(1);
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        data_d  = own_word;
        valid_d = 1'b1;
        if (!i_req[o_sel] || hold_q == HOLD_MAX) begin
          gnt_d   = '0;
          state_d = S_RELEASE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_RELEASE: begin
        gnt_d   = '0;
        hold_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        hold_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset points last owner at N_REQ-1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      o_gnt   <= '0;
      o_sel   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      hold_q  <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      o_gnt   <= gnt_d;
      o_sel   <= sel_d;
      o_data  <= data_d;
      o_valid <= valid_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign o_busy = (state_q == S_GRANT) || (state_q == S_RELEASE);

endmodule

// File: tb/tb_m_rr_bus_arbiter.sv
// Directed bench for the round-robin bus arbiter.
// Unit A uses MAX_HOLD=8, unit B uses MAX_HOLD=1.
module tb_m_rr_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_a, req_b;
  logic [63:0] data_a, data_b;
  logic [3:0]  gnt_a, gnt_b;
  logic [1:0]  sel_a, sel_b;
  logic [15:0] dout_a, dout_b;
  logic        valid_a, valid_b;
  logic        busy_a, busy_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  m_rr_bus_arbiter #(
    .N_REQ(4), .DATA_W(16), .SEL_W(2), .MAX_HOLD(8)
  ) u_a (
    .i_clk(clk), .i_rst(rst), .i_req(req_a), .i_data(data_a),
    .o_gnt(gnt_a), .o_sel(sel_a), .o_data(dout_a),
    .o_valid(valid_a), .o_busy(busy_a)
  );

  m_rr_bus_arbiter #(
    .N_REQ(4), .DATA_W(16), .SEL_W(2), .MAX_HOLD(1)
  ) u_b (
    .i_clk(clk), .i_rst(rst), .i_req(req_b), .i_data(data_b),
    .o_gnt(gnt_b), .o_sel(sel_b), .o_data(dout_b),
    .o_valid(valid_b), .o_busy(busy_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h want=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0]  oh;
    logic [15:0] w;
    int          vcnt;
    logic        seen;

    rst    = 1'b1;
    req_a  = '0;
    req_b  = '0;
    data_a = '0;
    data_b = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
    step();
    step();
    chk("rst_gnt",   32'(gnt_a),   32'h0);
    chk("rst_sel",   32'(sel_a),   32'h0);
    chk("rst_data",  32'(dout_a),  32'h0);
    chk("rst_valid", 32'(valid_a), 32'h0);
    chk("rst_busy",  32'(busy_a),  32'h0);
    rst = 1'b0;

    // lone requester 0, request held for three grant cycles
    data_a = {48'h0, 16'hBEEF};
    req_a  = 4'b0001;
    step();
    chk("t1_gnt",   32'(gnt_a),   32'h1);
    chk("t1_busy",  32'(busy_a),  32'h1);
    chk("t1_v0",    32'(valid_a), 32'h0);
    step();
    chk("t1_v1",    32'(valid_a), 32'h1);
    chk("t1_d1",    32'(dout_a),  32'hBEEF);
    step();
    chk("t1_v2",    32'(valid_a), 32'h1);
    req_a = 4'b0000;
    step();
    chk("t1_v3",    32'(valid_a), 32'h1);
    chk("t1_relg",  32'(gnt_a),   32'h0);
    chk("t1_relb",  32'(busy_a),  32'h1);
    step();
    chk("t1_idv",   32'(valid_a), 32'h0);
    chk("t1_idb",   32'(busy_a),  32'h0);
    chk("t1_hold",  32'(dout_a),  32'hBEEF);

    // all requesting: rotation 0,1,2,3,0 with 8 grant cycles each
    pulse_rst();
    data_a = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    req_a  = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      oh = 4'b0001 << (o % 4);
      w  = 16'hA000 + 16'(o % 4);
      step();
      chk("t2_gnt", 32'(gnt_a), 32'(oh));
      chk("t2_sel", 32'(sel_a), 32'(o % 4));
      vcnt = 0;
      for (int c = 1; c <= 8; c++) begin
        step();
        if (valid_a) vcnt++;
        if (c == 7) chk("t2_still", 32'(gnt_a), 32'(oh));
      end
      chk("t2_vcnt", 32'(vcnt),    32'd8);
      chk("t2_data", 32'(dout_a),  32'(w));
      chk("t2_rel",  32'(gnt_a),   32'h0);
      step();
      chk("t2_idle", 32'(busy_a),  32'h0);
    end

    // owner 2, requester 1 arrives mid-tenure, owner 2 drops
    pulse_rst();
    req_a = 4'b0100;
    step();
    chk("t3_gnt2", 32'(gnt_a), 32'h4);
    req_a = 4'b0110;
    step();
    chk("t3_keep", 32'(gnt_a), 32'h4);
    req_a = 4'b0010;
    step();
    chk("t3_rel",  32'(gnt_a), 32'h0);
    step();
    chk("t3_idle", 32'(gnt_a), 32'h0);
    step();
    chk("t3_gnt1", 32'(gnt_a), 32'h2);
    chk("t3_sel1", 32'(sel_a), 32'h1);
    req_a = 4'b0000;
    step();
    step();

    // async reset mid-grant, then pointer restart finds requester 3
    data_a = {48'h0, 16'h1234};
    req_a  = 4'b0001;
    step();
    step();
    step();
    chk("t5_pre_v", 32'(valid_a), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_gnt",  32'(gnt_a),   32'h0);
    chk("t5_val",  32'(valid_a), 32'h0);
    chk("t5_data", 32'(dout_a),  32'h0);
    chk("t5_busy", 32'(busy_a),  32'h0);
    step();
    rst   = 1'b0;
    req_a = 4'b1000;
    step();
    chk("t5_gnt3", 32'(gnt_a), 32'h8);
    chk("t5_sel3", 32'(sel_a), 32'h3);

    // one-cycle pulse from a non-owner is never granted
    pulse_rst();
    req_a = 4'b0001;
    seen  = 1'b0;
    step();
    chk("t6_gnt0", 32'(gnt_a), 32'h1);
    req_a = 4'b0011;
    step();
    seen |= gnt_a[1];
    req_a = 4'b0001;
    step();
    seen |= gnt_a[1];
    req_a = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      step();
      seen |= gnt_a[1];
    end
    chk("t6_never", 32'(seen),   32'h0);
    chk("t6_idle",  32'(busy_a), 32'h0);

    // MAX_HOLD=1 alternates 0,2 with single-cycle valid pulses
    pulse_rst();
    req_b = 4'b0101;
    for (int o = 0; o < 4; o++) begin
      oh = (o % 2 == 0) ? 4'b0001 : 4'b0100;
      w  = (o % 2 == 0) ? 16'hC000 : 16'hC002;
      step();
      chk("t4_gnt",  32'(gnt_b),   32'(oh));
      chk("t4_v0",   32'(valid_b), 32'h0);
      step();
      chk("t4_rel",  32'(gnt_b),   32'h0);
      chk("t4_v1",   32'(valid_b), 32'h1);
      chk("t4_data", 32'(dout_b),  32'(w));
      step();
      chk("t4_v2",   32'(valid_b), 32'h0);
    end
    req_b = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
